// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and defaults for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam logic [DEF_DATA_W-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/regfile_fwd_mux.sv
// regfile_fwd_mux: one read port. Selects between zero, a same-cycle
// forwarded write and the stored word, and raises a stall request while the
// operand is still owned by an in-flight producer.
module regfile_fwd_mux #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NWR    = 2
) (
  input  logic                         en,
  input  logic [ADDR_W-1:0]            raddr,
  input  logic [NWR-1:0]               wen,
  input  logic [NWR-1:0][ADDR_W-1:0]   waddr,
  input  logic [NWR-1:0][DATA_W-1:0]   wdata,
  input  logic [DATA_W-1:0]            mem_word,
  input  logic                         pend,
  output logic [DATA_W-1:0]            rdata,
  output logic                         rbusy
);

  logic              hit;
  logic [DATA_W-1:0] fwd_data;
  logic              addr_nz;

  assign addr_nz = (raddr != '0);

  // Forward from the highest-index write port that matches this address.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    for (int w = 0; w < NWR; w++) begin
      if (wen[w] && (waddr[w] == raddr) && addr_nz) begin
        hit      = 1'b1;
        fwd_data = wdata[w];
      end
    end
  end

  // Read priority: disabled/r0 give zero, then forwarding, then storage.
  always_comb begin
    rdata = '0;
    if (en && addr_nz) begin
      rdata = hit ? fwd_data : mem_word;
    end
  end

  assign rbusy = en & addr_nz & pend & ~hit;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NRD-read / NWR-write register file with write-to-read
// forwarding, per-entry pending bits and a post-reset clear sweep.
// Optional REGFILE_DEBUG_EN adds the REGS output (raw array view).
//
// state | meaning
// ------+-------------------------------------------------------------
// CLEAR | sweeping mem[cnt] <= 0; writes/reservations ignored; reads 0
// RUN   | normal operation, READY high
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = 2,
  parameter int NWR    = 2
) (
  input  logic                        CLK,
  input  logic                        RST,
  output logic                        READY,
  input  logic [NWR-1:0]              WEN,
  input  logic [NWR-1:0][ADDR_W-1:0]  WADDR,
  input  logic [NWR-1:0][DATA_W-1:0]  WDATA,
  input  logic                        RSV_EN,
  input  logic [ADDR_W-1:0]           RSV_ADDR,
  input  logic [NRD-1:0]              REN,
  input  logic [NRD-1:0][ADDR_W-1:0]  RADDR,
  output logic [NRD-1:0][DATA_W-1:0]  RDATA,
  output logic [NRD-1:0]              RBUSY
`ifdef REGFILE_DEBUG_EN
  ,
  output logic [(2**ADDR_W)-1:0][DATA_W-1:0] REGS
`endif
);

  localparam int DEPTH = 2**ADDR_W;

  rf_state_t         state;
  logic [ADDR_W-1:0] cnt;
  logic [DEPTH-1:0]  pending;
  logic [DATA_W-1:0] mem [DEPTH];

  // Sequencer, sweep counter, READY flag and scoreboard bits.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= CLEAR;
      cnt     <= '0;
      pending <= '0;
      READY   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + ADDR_W'(1);
          if (cnt == ADDR_W'(DEPTH-1)) begin
            state <= RUN;
            READY <= 1'b1;
          end
        end
        RUN: begin
          // Writes retire producers; a reservation in the same cycle is a
          // newer producer, so it is applied last and wins.
          for (int w = 0; w < NWR; w++) begin
            if (WEN[w] && (WADDR[w] != '0)) pending[WADDR[w]] <= 1'b0;
          end
          if (RSV_EN && (RSV_ADDR != '0)) pending[RSV_ADDR] <= 1'b1;
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Storage without reset so it can map to RAM; later ports override earlier.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state == CLEAR) begin
        mem[cnt] <= '0;
      end else begin
        for (int w = 0; w < NWR; w++) begin
          if (WEN[w] && (WADDR[w] != '0)) mem[WADDR[w]] <= WDATA[w];
        end
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_fwd_mux #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NWR    (NWR)
    ) u_mux (
      .en       (REN[i] & READY),
      .raddr    (RADDR[i]),
      .wen      (WEN),
      .waddr    (WADDR),
      .wdata    (WDATA),
      .mem_word (mem[RADDR[i]]),
      .pend     (pending[RADDR[i]]),
      .rdata    (RDATA[i]),
      .rbusy    (RBUSY[i])
    );
  end

`ifdef REGFILE_DEBUG_EN
  for (genvar k = 0; k < DEPTH; k++) begin : g_dbg
    assign REGS[k] = mem[k];
  end
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed, table-driven bench for regfile_mp (default params).
module tb_regfile_mp;
  import regfile_pkg::*;

  logic                 CLK;
  logic                 RST;
  logic                 READY;
  logic [1:0]           WEN;
  logic [1:0][4:0]      WADDR;
  logic [1:0][31:0]     WDATA;
  logic                 RSV_EN;
  logic [4:0]           RSV_ADDR;
  logic [1:0]           REN;
  logic [1:0][4:0]      RADDR;
  logic [1:0][31:0]     RDATA;
  logic [1:0]           RBUSY;
`ifdef REGFILE_DEBUG_EN
  logic [31:0][31:0]    REGS;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .NWR(2)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .READY    (READY),
    .WEN      (WEN),
    .WADDR    (WADDR),
    .WDATA    (WDATA),
    .RSV_EN   (RSV_EN),
    .RSV_ADDR (RSV_ADDR),
    .REN      (REN),
    .RADDR    (RADDR),
    .RDATA    (RDATA),
    .RBUSY    (RBUSY)
`ifdef REGFILE_DEBUG_EN
    ,
    .REGS     (REGS)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  wen;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        rsv;
    logic [4:0]  rsv_a;
    logic [1:0]  ren;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    WEN = 2'b00; WADDR = '0; WDATA = '0;
    RSV_EN = 1'b0; RSV_ADDR = '0;
    REN = 2'b00; RADDR = '0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    REN = 2'b11;
    RADDR[0] = a0;
    RADDR[1] = a1;
  endtask

  initial begin
    // wen wa0 wd0 wa1 wd1 rsv rsv_a ren ra0 ra1 exp0 exp1 expbusy
    vecs[0]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,        1'b0, 5'd0, 2'b11, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        2'b00};
    vecs[1]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0, 2'b11, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00};
    vecs[2]  = '{2'b11, 5'd7, 32'h11,       5'd7, 32'h22,       1'b0, 5'd0, 2'b11, 5'd7, 5'd5, 32'h22,       32'hDEADBEEF, 2'b00};
    vecs[3]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0, 2'b01, 5'd7, 5'd7, 32'h22,       32'h0,        2'b00};
    vecs[4]  = '{2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0,        1'b0, 5'd0, 2'b11, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00};
    vecs[5]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0, 2'b11, 5'd0, 5'd7, 32'h0,        32'h22,       2'b00};
    vecs[6]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b1, 5'd9, 2'b11, 5'd9, 5'd9, 32'h0,        32'h0,        2'b00};
    vecs[7]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0, 2'b11, 5'd9, 5'd5, 32'h0,        32'hDEADBEEF, 2'b01};
    vecs[8]  = '{2'b10, 5'd0, 32'h0,        5'd9, 32'h33,       1'b0, 5'd0, 2'b11, 5'd9, 5'd9, 32'h33,       32'h33,       2'b00};
    vecs[9]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0, 2'b11, 5'd9, 5'd0, 32'h33,       32'h0,        2'b00};
    vecs[10] = '{2'b01, 5'd9, 32'h44,       5'd0, 32'h0,        1'b1, 5'd9, 2'b01, 5'd9, 5'd0, 32'h44,       32'h0,        2'b00};
    vecs[11] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0, 2'b11, 5'd9, 5'd9, 32'h44,       32'h44,       2'b11};
    vecs[12] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b1, 5'd9, 2'b01, 5'd9, 5'd9, 32'h44,       32'h0,        2'b01};
    vecs[13] = '{2'b11, 5'd9, 32'h55,       5'd9, 32'h66,       1'b0, 5'd0, 2'b11, 5'd9, 5'd9, 32'h66,       32'h66,       2'b00};
    vecs[14] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0, 2'b11, 5'd9, 5'd7, 32'h66,       32'h22,       2'b00};
    vecs[15] = '{2'b10, 5'd0, 32'h0,        5'd6, 32'hA5A5A5A5, 1'b1, 5'd0, 2'b11, 5'd6, 5'd5, 32'hA5A5A5A5, 32'hDEADBEEF, 2'b00};
    vecs[16] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0, 2'b11, 5'd6, 5'd9, 32'hA5A5A5A5, 32'h66,       2'b00};

    idle();
    RST = 1'b1;
    tick();
    tick();
    rd(5'd5, 5'd9);
    #1;
    chk("rst_ready", 32'(READY), 32'h0);
    chk("rst_rdata0", RDATA[0], 32'h0);
    chk("rst_rbusy", 32'(RBUSY), 32'h0);

    // Sweep with writes/reservations presented; they must be ignored.
    RST = 1'b0;
    WEN = 2'b01; WADDR[0] = 5'd5; WDATA[0] = 32'h12345678;
    RSV_EN = 1'b1; RSV_ADDR = 5'd9;
    for (int k = 1; k <= 32; k++) begin
      if (k < 32) begin
        chk("sweep_rdata", RDATA[0], 32'h0);
      end
      tick();
      chk($sformatf("sweep_ready_e%0d", k), 32'(READY), (k == 32) ? 32'h1 : 32'h0);
    end
    idle();
    rd(5'd5, 5'd9);
    #1;
    chk("sweep_wr_ignored", RDATA[0], 32'h0);
    chk("sweep_rsv_ignored", 32'(RBUSY), 32'h0);

    for (int v = 0; v < 17; v++) begin
      WEN = vecs[v].wen;
      WADDR[0] = vecs[v].wa0; WDATA[0] = vecs[v].wd0;
      WADDR[1] = vecs[v].wa1; WDATA[1] = vecs[v].wd1;
      RSV_EN = vecs[v].rsv; RSV_ADDR = vecs[v].rsv_a;
      REN = vecs[v].ren;
      RADDR[0] = vecs[v].ra0; RADDR[1] = vecs[v].ra1;
      #1;
      chk($sformatf("v%0d_rdata0", v), RDATA[0], vecs[v].e0);
      chk($sformatf("v%0d_rdata1", v), RDATA[1], vecs[v].e1);
      chk($sformatf("v%0d_rbusy", v), 32'(RBUSY), 32'(vecs[v].eb));
      tick();
    end

    // Leave r9 pending, then reset mid-sweep.
    idle();
    RSV_EN = 1'b1; RSV_ADDR = 5'd9;
    tick();
    idle();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("mid_ready_cnt10", 32'(READY), 32'h0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k >= 31) begin
        chk($sformatf("restart_ready_e%0d", k), 32'(READY), (k == 32) ? 32'h1 : 32'h0);
      end
    end
    rd(5'd5, 5'd9);
    #1;
    chk("post_rst_r5", RDATA[0], 32'h0);
    chk("post_rst_r9", RDATA[1], 32'h0);
    chk("post_rst_busy", 32'(RBUSY), 32'h0);
    rd(5'd7, 5'd6);
    #1;
    chk("post_rst_r7", RDATA[0], 32'h0);
    chk("post_rst_r6", RDATA[1], 32'h0);

`ifdef REGFILE_DEBUG_EN
    idle();
    WEN = 2'b01; WADDR[0] = 5'd3; WDATA[0] = 32'h44;
    tick();
    idle();
    #1;
    chk("dbg_regs3", REGS[3], 32'h44);
    chk("dbg_regs0", REGS[0], ZERO_WORD);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
